// File: rtl/ball_direction_ctrl_pkg.sv
// Shared constants for the ball direction controller.
//   - FSM state encodings (SERVE/PLAY/MISS)
//   - direction polarity constants
//   - default visible geometry and serve hold length
//   - per-frame collision flag bundle
package ball_direction_ctrl_pkg;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_MISS  = 2'd2;

  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int H_VISIBLE_DEF    = 640;
  localparam int V_VISIBLE_DEF    = 480;
  localparam int SERVE_FRAMES_DEF = 60;

  // Sticky events collected over one visible frame.
  typedef struct packed {
    logic top;
    logic bot;
    logic pad_l;
    logic pad_r;
    logic miss_l;
    logic miss_r;
  } hit_flags_t;

endpackage

// File: rtl/ball_direction_ctrl_beam.sv
// beam_position: tracks where the beam is inside the visible frame.
// Ports:
//   i_Clk, i_Rst_n       clock, async active-low reset
//   i_HBlank, i_VBlank   blanking from the VGA timing block
//   col, line            visible column / line (saturating)
//   vblank_rise          one-clock strobe on the VBlank rising edge
//   visible              beam inside visible video
module beam_position #(
  parameter int p_H_VISIBLE = 640,
  parameter int p_V_VISIBLE = 480,
  localparam int CW = $clog2(p_H_VISIBLE),
  localparam int LW = $clog2(p_V_VISIBLE)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_HBlank,
  input  logic          i_VBlank,
  output logic [CW-1:0] col,
  output logic [LW-1:0] line,
  output logic          vblank_rise,
  output logic          visible
);

  localparam logic [CW-1:0] COL_MAX  = '1;
  localparam logic [LW-1:0] LINE_MAX = '1;

  // Blanking history resets high so reset release never looks like an edge.
  logic          hblank_q, vblank_q;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d;
  logic          hblank_rise;

  assign hblank_rise = i_HBlank & ~hblank_q;
  assign vblank_rise = i_VBlank & ~vblank_q;
  assign visible     = ~i_HBlank & ~i_VBlank;
  assign col         = col_q;
  assign line        = line_q;

  always_comb begin
    col_d = col_q;
    if (i_HBlank)             col_d = '0;
    else if (col_q != COL_MAX) col_d = col_q + CW'(1);

    line_d = line_q;
    if (i_VBlank)                             line_d = '0;
    else if (hblank_rise && line_q != LINE_MAX) line_d = line_q + LW'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      col_q    <= '0;
      line_q   <= '0;
    end else begin
      hblank_q <= i_HBlank;
      vblank_q <= i_VBlank;
      col_q    <= col_d;
      line_q   <= line_d;
    end
  end

endmodule

// File: rtl/ball_direction_ctrl.sv
// ball_direction_ctrl: collects ball/paddle/edge events during each visible
// frame and commits ball direction, freeze and score on the VBlank rise.
// Ports:
//   i_Clk, i_Rst_n                       clock, async active-low reset
//   i_HBlank, i_VBlank                   VGA blanking
//   i_Ball_Video, i_Paddle_L/R_Video     object pixel activity
//   o_VDir (1=down), o_HDir (1=right)    ball direction
//   o_Freeze                             hold ball (SERVE, MISS)
//   o_Score_L, o_Score_R                 one-clock score pulses
module ball_direction_ctrl
  import ball_direction_ctrl_pkg::*;
#(
  parameter int p_H_VISIBLE    = H_VISIBLE_DEF,
  parameter int p_V_VISIBLE    = V_VISIBLE_DEF,
  parameter int p_SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_HBlank,
  input  logic i_VBlank,
  input  logic i_Ball_Video,
  input  logic i_Paddle_L_Video,
  input  logic i_Paddle_R_Video,
  output logic o_VDir,
  output logic o_HDir,
  output logic o_Freeze,
  output logic o_Score_L,
  output logic o_Score_R
);

  localparam int CW  = $clog2(p_H_VISIBLE);
  localparam int LW  = $clog2(p_V_VISIBLE);
  localparam int SCW = $clog2(p_SERVE_FRAMES + 1);
  localparam logic [SCW-1:0] CNT_MAX  = '1;
  localparam logic [SCW-1:0] CNT_LAST = SCW'(p_SERVE_FRAMES - 1);

  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic          vblank_rise, visible;

  beam_position #(
    .p_H_VISIBLE (p_H_VISIBLE),
    .p_V_VISIBLE (p_V_VISIBLE)
  ) u_beam (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_HBlank    (i_HBlank),
    .i_VBlank    (i_VBlank),
    .col         (col),
    .line        (line),
    .vblank_rise (vblank_rise),
    .visible     (visible)
  );

  logic [1:0]     state_q, state_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  hit_flags_t     flags_q, flags_d;
  logic           vdir_q, vdir_d, hdir_q, hdir_d, freeze_q, freeze_d;
  logic           score_l_q, score_l_d, score_r_q, score_r_d;
  logic           miss_l_eff, miss_r_eff;

  // A paddle contact on the same side rescues the ball.
  assign miss_l_eff = flags_q.miss_l & ~flags_q.pad_l;
  assign miss_r_eff = flags_q.miss_r & ~flags_q.pad_r;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flags_d   = flags_q;
    vdir_d    = vdir_q;
    hdir_d    = hdir_q;
    freeze_d  = freeze_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;

    if (visible && i_Ball_Video) begin
      if (line == '0)                     flags_d.top    = 1'b1;
      if (line == LW'(p_V_VISIBLE - 1))   flags_d.bot    = 1'b1;
      if (i_Paddle_L_Video)               flags_d.pad_l  = 1'b1;
      if (i_Paddle_R_Video)               flags_d.pad_r  = 1'b1;
      if (col == '0)                      flags_d.miss_l = 1'b1;
      if (col == CW'(p_H_VISIBLE - 1))    flags_d.miss_r = 1'b1;
    end

    if (vblank_rise) begin
      flags_d = '0;

      // Vertical bounce is honoured even while frozen.
      if (flags_q.top && !flags_q.bot)      vdir_d = DIR_DOWN;
      else if (flags_q.bot && !flags_q.top) vdir_d = ~DIR_DOWN;

      case (state_q)
        ST_SERVE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + SCW'(1);
          end
        end
        ST_PLAY: begin
          if (miss_l_eff) begin
            state_d   = ST_MISS;
            score_r_d = 1'b1;
            hdir_d    = DIR_RIGHT;
          end else if (miss_r_eff) begin
            state_d   = ST_MISS;
            score_l_d = 1'b1;
            hdir_d    = ~DIR_RIGHT;
          end else if (flags_q.pad_l && !flags_q.pad_r) begin
            hdir_d = DIR_RIGHT;
          end else if (flags_q.pad_r && !flags_q.pad_l) begin
            hdir_d = ~DIR_RIGHT;
          end
        end
        ST_MISS: state_d = ST_SERVE;
        default: state_d = ST_SERVE;
      endcase

      freeze_d = (state_d != ST_PLAY);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_SERVE;
      cnt_q     <= '0;
      flags_q   <= '0;
      vdir_q    <= DIR_DOWN;
      hdir_q    <= DIR_RIGHT;
      freeze_q  <= 1'b1;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      vdir_q    <= vdir_d;
      hdir_q    <= hdir_d;
      freeze_q  <= freeze_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign o_VDir    = vdir_q;
  assign o_HDir    = hdir_q;
  assign o_Freeze  = freeze_q;
  assign o_Score_L = score_l_q;
  assign o_Score_R = score_r_q;

endmodule

// File: tb/tb_ball_direction_ctrl.sv
module tb_ball_direction_ctrl;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int SF = 2;

  logic i_Clk = 1'b0;
  logic i_Rst_n = 1'b0;
  logic i_HBlank = 1'b1, i_VBlank = 1'b1;
  logic i_Ball_Video = 1'b0, i_Paddle_L_Video = 1'b0, i_Paddle_R_Video = 1'b0;
  logic o_VDir, o_HDir, o_Freeze, o_Score_L, o_Score_R;

  always #5 i_Clk = ~i_Clk;

  ball_direction_ctrl #(
    .p_H_VISIBLE    (H),
    .p_V_VISIBLE    (V),
    .p_SERVE_FRAMES (SF)
  ) dut (
    .i_Clk            (i_Clk),
    .i_Rst_n          (i_Rst_n),
    .i_HBlank         (i_HBlank),
    .i_VBlank         (i_VBlank),
    .i_Ball_Video     (i_Ball_Video),
    .i_Paddle_L_Video (i_Paddle_L_Video),
    .i_Paddle_R_Video (i_Paddle_R_Video),
    .o_VDir           (o_VDir),
    .o_HDir           (o_HDir),
    .o_Freeze         (o_Freeze),
    .o_Score_L        (o_Score_L),
    .o_Score_R        (o_Score_R)
  );

  typedef struct {
    bit vdir, hdir, freeze, sl, sr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Frame-level reference: hold = commits remaining before the ball is live.
  int m_hold;
  bit m_vdir, m_hdir;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_hold = SF;
    m_vdir = 1'b1;
    m_hdir = 1'b1;
  endfunction

  function automatic void model_commit(input bit top, bot, pl, pr, ml, mr);
    exp_t e;
    e.sl = 1'b0;
    e.sr = 1'b0;
    if (top != bot) m_vdir = top;
    if (m_hold > 0) m_hold--;
    else if (ml && !pl) begin e.sr = 1'b1; m_hdir = 1'b1; m_hold = SF + 1; end
    else if (mr && !pr) begin e.sl = 1'b1; m_hdir = 1'b0; m_hold = SF + 1; end
    else if (pl != pr)  m_hdir = pl;
    e.vdir   = m_vdir;
    e.hdir   = m_hdir;
    e.freeze = (m_hold > 0);
    exp_q.push_back(e);
  endfunction

  task automatic do_reset();
    i_Rst_n = 1'b0;
    #1;
    chk("rst_vdir",   o_VDir,    1'b1);
    chk("rst_hdir",   o_HDir,    1'b1);
    chk("rst_freeze", o_Freeze,  1'b1);
    chk("rst_score_l", o_Score_L, 1'b0);
    chk("rst_score_r", o_Score_R, 1'b0);
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;
    model_reset();
  endtask

  // One frame with a single-pixel ball at (bx,by); paddles occupy the two
  // outermost columns on every line. rst_line >= 0 pulses reset mid-line.
  task automatic run_frame(input bit bp, input int bx, input int by,
                           input bit pl, input bit pr, input int rst_line);
    for (int l = 0; l < V; l++) begin
      for (int c = 0; c < H; c++) begin
        i_HBlank         = 1'b0;
        i_VBlank         = 1'b0;
        i_Ball_Video     = bp && c == bx && l == by;
        i_Paddle_L_Video = pl && c <= 1;
        i_Paddle_R_Video = pr && c >= H - 2;
        @(posedge i_Clk);
        #1;
        if (l == rst_line && c == 4) begin
          i_Ball_Video = 1'b0;
          do_reset();
        end
      end
      i_Ball_Video = 1'b0;
      i_Paddle_L_Video = 1'b0;
      i_Paddle_R_Video = 1'b0;
      i_HBlank = 1'b1;
      repeat (3) @(posedge i_Clk);
      #1;
    end
    if (rst_line >= 0)
      model_commit(0, 0, 0, 0, 0, 0);
    else
      model_commit(bp && by == 0, bp && by == V - 1,
                   bp && pl && bx <= 1, bp && pr && bx >= H - 2,
                   bp && bx == 0, bp && bx == H - 1);
    i_VBlank = 1'b1;
    repeat (5) @(posedge i_Clk);
    #1;
  endtask

  // Monitor: each VBlank rise is a commit; compare on the sample after it,
  // then confirm score pulses drop one clock later.
  initial begin
    bit   vb_prev;
    exp_t e;
    vb_prev = 1'b1;
    forever begin
      @(negedge i_Clk);
      if (i_VBlank && !vb_prev && i_Rst_n) begin
        @(negedge i_Clk);
        if (exp_q.size() == 0) begin
          chk("no_expected_commit", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("vdir",    o_VDir,    e.vdir);
          chk("hdir",    o_HDir,    e.hdir);
          chk("freeze",  o_Freeze,  e.freeze);
          chk("score_l", o_Score_L, e.sl);
          chk("score_r", o_Score_R, e.sr);
        end
        @(negedge i_Clk);
        chk("score_l_width", o_Score_L, 1'b0);
        chk("score_r_width", o_Score_R, 1'b0);
      end
      vb_prev = i_VBlank;
    end
  end

  initial begin
    int bx, by;
    model_reset();
    #12;
    chk("init_vdir",    o_VDir,    1'b1);
    chk("init_hdir",    o_HDir,    1'b1);
    chk("init_freeze",  o_Freeze,  1'b1);
    chk("init_score_l", o_Score_L, 1'b0);
    chk("init_score_r", o_Score_R, 1'b0);
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;

    // Serve hold, then play.
    run_frame(0, 0, 0, 0, 0, -1);
    run_frame(0, 0, 0, 0, 0, -1);
    // Vertical bounces.
    run_frame(1, 3, V - 1, 0, 0, -1);
    run_frame(1, 3, 0, 0, 0, -1);
    // Right paddle return, then left miss and the serve sequence.
    run_frame(1, H - 1, 2, 0, 1, -1);
    run_frame(1, 0, 2, 0, 0, -1);
    run_frame(0, 0, 0, 0, 0, -1);
    run_frame(0, 0, 0, 0, 0, -1);
    run_frame(0, 0, 0, 0, 0, -1);
    // Paddle save at column 0 overrides the miss.
    run_frame(1, H - 2, 1, 0, 1, -1);
    run_frame(1, 0, 3, 1, 0, -1);
    // Right miss; top hit while serving still bounces, horizontal ignored.
    run_frame(1, 2, V - 1, 0, 0, -1);
    run_frame(1, H - 1, 3, 0, 0, -1);
    run_frame(0, 0, 0, 0, 0, -1);
    run_frame(1, 0, 0, 1, 0, -1);
    run_frame(0, 0, 0, 0, 0, -1);
    // Drive state away from reset values, then reset mid-frame.
    run_frame(1, 3, V - 1, 0, 1, -1);
    run_frame(1, H - 1, 2, 0, 1, -1);
    run_frame(1, 0, V - 1, 0, 0, V - 1);
    run_frame(0, 0, 0, 0, 0, -1);

    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 3))
        0:       bx = 0;
        1:       bx = H - 1;
        default: bx = $urandom_range(0, H - 1);
      endcase
      case ($urandom_range(0, 3))
        0:       by = 0;
        1:       by = V - 1;
        default: by = $urandom_range(0, V - 1);
      endcase
      run_frame($urandom_range(0, 3) != 0, bx, by,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1);
    end

    repeat (10) @(posedge i_Clk);
    chk("queue_drained", exp_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
